// File: rtl/serial_pkg.sv
// Shared serial-link definitions: receiver FSM encoding, frame width and
// the parity helper used by the receiver and the transmitters.
package serial_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned CNT_W     = $clog2(DATA_BITS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } serial_state_e;

  // Payload presented on the parallel side after a frame with a good stop bit.
  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 par_err;
  } rx_frame_t;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/serial_sync_receiver_if.sv
// Serial-line and parallel-result bundle for the synchronous serial receiver.
interface serial_sync_receiver_if;

  logic                             sc_in;
  logic                             sd_in;
  logic [serial_pkg::DATA_BITS-1:0] pd_out;
  logic                             pd_ready;
  logic                             par_err;
  logic                             frame_err;
  logic                             busy;

  modport master (
    output sc_in,
    output sd_in,
    input  pd_out,
    input  pd_ready,
    input  par_err,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  sc_in,
    input  sd_in,
    output pd_out,
    output pd_ready,
    output par_err,
    output frame_err,
    output busy
  );

endinterface

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit; resets to RESET_VAL
// so an idle-high line does not produce a spurious edge after reset.
module bit_synchronizer #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic q_out
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_out = sync_q[STAGES-1];

endmodule

// File: rtl/serial_sync_receiver.sv
// Receives start / 8 data (LSB first) / even parity / stop frames clocked by an
// external bit clock, oversampled and synchronized into the ClkIn domain.
module serial_sync_receiver
  import serial_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 ClkIn,
  input  logic                 Rst_n,
  input  logic                 SCin,
  input  logic                 SDin,
  output logic [DATA_BITS-1:0] PDout,
  output logic                 PDready,
  output logic                 ParErr,
  output logic                 FrameErr,
  output logic                 Busy
);

  logic sc_sync;
  logic sd_sync;

  bit_synchronizer #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sc_sync (
    .clk   (ClkIn),
    .rst_n (Rst_n),
    .d_in  (SCin),
    .q_out (sc_sync)
  );

  bit_synchronizer #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sd_sync (
    .clk   (ClkIn),
    .rst_n (Rst_n),
    .d_in  (SDin),
    .q_out (sd_sync)
  );

  serial_state_e        state_q,     state_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;
  logic [DATA_BITS-1:0] shreg_q,     shreg_d;
  logic                 par_bit_q,   par_bit_d;
  rx_frame_t            frame_q,     frame_d;
  logic                 sc_prev_q,   sc_prev_d;
  logic                 pdready_q,   pdready_d;
  logic                 frameerr_q,  frameerr_d;
  logic                 busy_q,      busy_d;
  logic                 sclk_rise_c;

  // Next-state and output decode; every FSM move is gated by a bit-clock rise.
  always_comb begin
    sclk_rise_c = sc_sync & ~sc_prev_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    par_bit_d   = par_bit_q;
    frame_d     = frame_q;
    sc_prev_d   = sc_sync;
    pdready_d   = 1'b0;
    frameerr_d  = 1'b0;

    if (sclk_rise_c) begin
      unique case (state_q)
        IDLE: begin
          if (!sd_sync) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shreg_d = {sd_sync, shreg_q[DATA_BITS-1:1]};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          par_bit_d = sd_sync;
          state_d   = STOP;
        end
        STOP: begin
          // A bad stop bit leaves the previously delivered frame untouched.
          if (sd_sync) begin
            frame_d.data    = shreg_q;
            frame_d.par_err = even_parity(shreg_q) ^ par_bit_q;
            pdready_d       = 1'b1;
          end else begin
            frameerr_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge ClkIn or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      par_bit_q  <= 1'b0;
      frame_q    <= '0;
      sc_prev_q  <= 1'b1;
      pdready_q  <= 1'b0;
      frameerr_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      par_bit_q  <= par_bit_d;
      frame_q    <= frame_d;
      sc_prev_q  <= sc_prev_d;
      pdready_q  <= pdready_d;
      frameerr_q <= frameerr_d;
      busy_q     <= busy_d;
    end
  end

  assign PDout    = frame_q.data;
  assign ParErr   = frame_q.par_err;
  assign PDready  = pdready_q;
  assign FrameErr = frameerr_q;
  assign Busy     = busy_q;

endmodule

// File: tb/tb_serial_sync_receiver.sv
// Scoreboard bench for serial_sync_receiver: directed and random frames are
// modelled at issue time; a monitor checks every DUT output pulse and hold.
module tb_serial_sync_receiver;
  import serial_pkg::*;

  logic ClkIn = 1'b0;
  logic Rst_n = 1'b0;

  serial_sync_receiver_if rx_if ();

  serial_sync_receiver #(
    .SYNC_STAGES (2)
  ) dut (
    .ClkIn    (ClkIn),
    .Rst_n    (Rst_n),
    .SCin     (rx_if.sc_in),
    .SDin     (rx_if.sd_in),
    .PDout    (rx_if.pd_out),
    .PDready  (rx_if.pd_ready),
    .ParErr   (rx_if.par_err),
    .FrameErr (rx_if.frame_err),
    .Busy     (rx_if.busy)
  );

  always #5 ClkIn = ~ClkIn;

  typedef struct packed {
    logic       is_frame_err;
    logic [7:0] data;
    logic       par_err;
  } exp_t;

  exp_t       exp_q[$];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] model_pd  = 8'h00;
  logic       model_par = 1'b0;
  logic [7:0] mon_pd    = 8'h00;
  logic       mon_par   = 1'b0;
  logic       prev_evt  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every PDready/FrameErr, checks holds otherwise.
  initial begin
    exp_t e;
    forever begin
      @(negedge ClkIn);
      if (!Rst_n) begin
        check("reset_pdout", 32'(rx_if.pd_out), 32'h00);
        check("reset_pdready", 32'(rx_if.pd_ready), 32'h0);
        check("reset_parerr", 32'(rx_if.par_err), 32'h0);
        check("reset_frameerr", 32'(rx_if.frame_err), 32'h0);
        check("reset_busy", 32'(rx_if.busy), 32'h0);
        mon_pd   = 8'h00;
        mon_par  = 1'b0;
        prev_evt = 1'b0;
      end else if (rx_if.pd_ready || rx_if.frame_err) begin
        check("pulse_width_one_cycle", 32'(prev_evt), 32'h0);
        check("pulse_exclusive", 32'(rx_if.pd_ready & rx_if.frame_err), 32'h0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: PDready=%0d FrameErr=%0d, required no pulse",
                   rx_if.pd_ready, rx_if.frame_err);
        end else begin
          e = exp_q.pop_front();
          check("event_is_frame_err", 32'(rx_if.frame_err), 32'(e.is_frame_err));
          check("pdout", 32'(rx_if.pd_out), 32'(e.data));
          check("parerr", 32'(rx_if.par_err), 32'(e.par_err));
          mon_pd  = e.data;
          mon_par = e.par_err;
        end
        prev_evt = 1'b1;
      end else begin
        check("pdout_hold", 32'(rx_if.pd_out), 32'(mon_pd));
        check("parerr_hold", 32'(rx_if.par_err), 32'(mon_par));
        prev_evt = 1'b0;
      end
    end
  end

  // kind: 0 idle, 1 start, 2 data, 3 parity, 4 stop. Entered just after a posedge.
  task automatic send_bit(input logic b, input int kind);
    int lo;
    int hi;
    lo = int'($urandom_range(3, 7));
    hi = int'($urandom_range(3, 7));
    rx_if.sd_in = b;
    repeat (lo) @(posedge ClkIn);
    #1 rx_if.sc_in = 1'b1;
    repeat (2) @(posedge ClkIn);
    @(negedge ClkIn);
    if (kind == 4) check("no_event_before_edge3", 32'(rx_if.pd_ready | rx_if.frame_err), 32'h0);
    @(posedge ClkIn);
    @(negedge ClkIn);
    case (kind)
      0: check("busy_while_idle", 32'(rx_if.busy), 32'h0);
      1: check("busy_after_start", 32'(rx_if.busy), 32'h1);
      4: begin
        check("event_latency_edge3", 32'(rx_if.pd_ready | rx_if.frame_err), 32'h1);
        check("busy_after_stop", 32'(rx_if.busy), 32'h0);
      end
      default: ;
    endcase
    repeat (hi - 3) @(posedge ClkIn);
    #1 rx_if.sc_in = 1'b0;
  endtask

  // Reference model: a good stop delivers the data with parity status, a bad
  // stop reports a framing error while the last good frame stays visible.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    logic pe;
    pe = (($countones(d) % 2) == 1) != (p == 1'b1);
    if (s) begin
      exp_q.push_back('{is_frame_err: 1'b0, data: d, par_err: pe});
      model_pd  = d;
      model_par = pe;
    end else begin
      exp_q.push_back('{is_frame_err: 1'b1, data: model_pd, par_err: model_par});
    end
    send_bit(1'b0, 1);
    for (int i = 0; i < 8; i++) send_bit(d[i], 2);
    send_bit(p, 3);
    send_bit(s, 4);
  endtask

  initial begin
    logic [7:0] rd;
    logic       rp;
    logic       rs;
    int         n_idle;

    rx_if.sc_in = 1'b0;
    rx_if.sd_in = 1'b1;
    Rst_n       = 1'b0;
    repeat (4) @(posedge ClkIn);
    #1 Rst_n = 1'b1;
    repeat (2) @(posedge ClkIn);
    #1;

    send_frame(8'hA5, 1'b0, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b1);
    send_frame(8'h01, 1'b1, 1'b1);

    // Abort a frame after four data bits with reset; nothing should be reported.
    send_bit(1'b0, 1);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 2);
    Rst_n = 1'b0;
    model_pd  = 8'h00;
    model_par = 1'b0;
    repeat (3) @(posedge ClkIn);
    @(negedge ClkIn);
    check("reset_midframe_busy", 32'(rx_if.busy), 32'h0);
    check("reset_midframe_pdout", 32'(rx_if.pd_out), 32'h00);
    rx_if.sd_in = 1'b1;
    @(posedge ClkIn);
    #1 Rst_n = 1'b1;
    repeat (2) @(posedge ClkIn);
    #1;
    send_frame(8'h81, 1'b0, 1'b1);

    for (int i = 0; i < 20; i++) send_bit(1'b1, 0);
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);

    for (int f = 0; f < 40; f++) begin
      rd = 8'($urandom);
      rp = ($urandom_range(0, 3) == 0) ? ~(^rd) : (^rd);
      rs = ($urandom_range(0, 5) != 0);
      n_idle = int'($urandom_range(0, 2));
      for (int k = 0; k < n_idle; k++) send_bit(1'b1, 0);
      send_frame(rd, rp, rs);
    end

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge ClkIn);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    repeat (4) @(posedge ClkIn);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_sync_receiver.md
SERIAL_SYNC_RECEIVER -- requirements
Module: serial_sync_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of synchronizer flops on SCin and SDin (legal range 2..4).
REQ-002 SHALL have port ClkIn, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port Rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port SCin, input, 1, the serial bit clock from the transmitter, asynchronous to ClkIn.
REQ-005 SHALL have port SDin, input, 1, the serial data line, which idles high.
REQ-006 SHALL have port PDout, output, 8, the last frame received with a valid stop bit.
REQ-007 SHALL have port PDready, output, 1, a one-ClkIn-cycle pulse marking a PDout update.
REQ-008 SHALL have port ParErr, output, 1, the parity status of the frame currently on PDout.
REQ-009 SHALL have port FrameErr, output, 1, a one-cycle pulse on a stop-bit error.
REQ-010 SHALL have port Busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-011 SHALL pass SCin and SDin through SYNC_STAGES-deep flop synchronizers clocked by ClkIn.
REQ-012 SHALL generate sclk_rise for one cycle when the synchronized SCin is 1 and its registered copy is 0; all sampling uses the synchronized SDin in that cycle only.
REQ-013 SHALL receive frames in this order: start bit (0), 8 data bits LSB first, even-parity bit (XOR of the data bits), stop bit (1).
REQ-014 SHALL implement FSM states IDLE, DATA, PARITY, STOP, with every transition taken only on sclk_rise.
REQ-015 IDLE: sclk_rise with SDin=0 -> DATA with bit count cleared; SDin=1 -> stay in IDLE.
REQ-016 DATA: each sclk_rise SHALL shift SDin into the shift register MSB (shift right) and increment a 3-bit count; after the 8th bit -> PARITY.
REQ-017 PARITY: sclk_rise SHALL capture the parity bit -> STOP.
REQ-018 STOP with SDin=1: SHALL load PDout from the shift register, pulse PDready, and set ParErr to (XOR of data) XOR (parity bit), all in the same cycle; then -> IDLE.
REQ-019 STOP with SDin=0: SHALL pulse FrameErr and leave PDout and ParErr unchanged, with no PDready; then -> IDLE.
REQ-020 With SYNC_STAGES=2, PDready/FrameErr SHALL be high in the cycle after the 3rd ClkIn edge, counting the first edge that samples the stop-bit SCin high as edge 1.
REQ-021 SHALL accept back-to-back frames: the next start bit may arrive on the very next SCin rising edge after the stop bit.
REQ-022 SHALL hold PDout and ParErr between valid frames.
REQ-023 SHALL operate correctly only when SCin high and low phases each last at least SYNC_STAGES+1 ClkIn periods; slower SCin is unconstrained.

Reset
REQ-024 While Rst_n=0, SHALL force FSM=IDLE, count=0, shift register=0, PDout=8'h00, PDready=0, ParErr=0, FrameErr=0, Busy=0, and synchronizer flops to 1.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; the first complete frame after release SHALL be received normally.

Structure
REQ-026 SHALL place the FSM state encoding (IDLE, DATA, PARITY, STOP) and DATA_BITS=8 in shared package serial_pkg, which the transmitters also use.
REQ-027 SHALL instantiate a sub-module bit_synchronizer (parameter STAGES, reset value 1) once each for SCin and SDin.

Verification
REQ-028 Frame 0xA5 with parity 0 and stop 1 -> PDout=8'hA5, PDready high for exactly 1 cycle, ParErr=0, FrameErr=0.
REQ-029 Frame 0x3C with wrong parity 1 -> PDout=8'h3C, PDready pulse, ParErr=1; a following good frame 0x01 with parity 1 -> ParErr=0.
REQ-030 Frame 0x5A with stop bit 0 -> FrameErr pulse, no PDready, PDout keeps the previous value 8'hA5.
REQ-031 Rst_n low after 4 data bits, then frame 0x81 with parity 0 -> PDout=8'h81, exactly one PDready.
REQ-032 SDin held at 1 with 20 SCin edges -> Busy stays 0 and no PDready; then back-to-back 0x00 and 0xFF frames -> two PDready pulses with PDout 8'h00 then 8'hFF.
